// File: rtl/ahb_response_mux.sv
// AHB data-phase return mux: registers the decoder's one-hot select and routes
// slave responses back to the master, with a built-in ERROR-returning default slave.
module ahb_response_mux #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic [3:0]            hsel,
  input  logic [1:0]            htrans,
  input  logic                  hreadyout_s0,
  input  logic                  hreadyout_s1,
  input  logic                  hreadyout_s2,
  input  logic                  hresp_s0,
  input  logic                  hresp_s1,
  input  logic                  hresp_s2,
  input  logic [DATA_WIDTH-1:0] hrdata_s0,
  input  logic [DATA_WIDTH-1:0] hrdata_s1,
  input  logic [DATA_WIDTH-1:0] hrdata_s2,
  output logic                  hready,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  typedef enum logic [1:0] {SEL_DEF = 2'd0, SEL_S0 = 2'd1, SEL_S1 = 2'd2, SEL_S2 = 2'd3} sel_e;
  typedef enum logic [1:0] {DS_IDLE = 2'd0, DS_ERR1 = 2'd1, DS_ERR2 = 2'd2} ds_e;

  sel_e dsel, sel_enc;
  ds_e  ds_state, ds_next;
  logic ds_ready, ds_resp;

  // Only clean one-hot patterns reach a real slave; everything else is unmapped.
  always_comb begin
    sel_enc = SEL_DEF;
    case (hsel)
      4'b0001: sel_enc = SEL_S0;
      4'b0010: sel_enc = SEL_S1;
      4'b0100: sel_enc = SEL_S2;
      default: sel_enc = SEL_DEF;
    endcase
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      dsel     <= SEL_DEF;
      ds_state <= DS_IDLE;
    end else begin
      if (hready) dsel <= sel_enc;
      ds_state <= ds_next;
    end
  end

  // Default slave: two-cycle ERROR for active unmapped transfers, zero-wait OKAY otherwise.
  always_comb begin
    ds_next  = ds_state;
    ds_ready = 1'b1;
    ds_resp  = 1'b0;
    case (ds_state)
      DS_ERR1: begin
        ds_ready = 1'b0;
        ds_resp  = 1'b1;
        ds_next  = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp = 1'b1;
        ds_next = (hready && sel_enc == SEL_DEF && htrans[1]) ? DS_ERR1 : DS_IDLE;
      end
      default: begin
        ds_next = (hready && sel_enc == SEL_DEF && htrans[1]) ? DS_ERR1 : DS_IDLE;
      end
    endcase
  end

  always_comb begin
    hready = ds_ready;
    hresp  = ds_resp;
    hrdata = '0;
    case (dsel)
      SEL_S0: begin
        hready = hreadyout_s0;
        hresp  = hresp_s0;
        hrdata = hrdata_s0;
      end
      SEL_S1: begin
        hready = hreadyout_s1;
        hresp  = hresp_s1;
        hrdata = hrdata_s1;
      end
      SEL_S2: begin
        hready = hreadyout_s2;
        hresp  = hresp_s2;
        hrdata = hrdata_s2;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ahb_response_mux.sv
// Directed bench for ahb_response_mux: slave routing, wait states, default-slave
// ERROR sequencing and asynchronous reset.
module tb_ahb_response_mux;
  localparam int DW = 32;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [3:0]    hsel;
  logic [1:0]    htrans;
  logic          hreadyout_s0, hreadyout_s1, hreadyout_s2;
  logic          hresp_s0, hresp_s1, hresp_s2;
  logic [DW-1:0] hrdata_s0, hrdata_s1, hrdata_s2;
  logic          hready, hresp;
  logic [DW-1:0] hrdata;

  int nvec = 0;
  int nerr = 0;

  ahb_response_mux #(.DATA_WIDTH(DW)) dut (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel), .htrans(htrans),
    .hreadyout_s0(hreadyout_s0), .hreadyout_s1(hreadyout_s1), .hreadyout_s2(hreadyout_s2),
    .hresp_s0(hresp_s0), .hresp_s1(hresp_s1), .hresp_s2(hresp_s2),
    .hrdata_s0(hrdata_s0), .hrdata_s1(hrdata_s1), .hrdata_s2(hrdata_s2),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_bus(input string tag, input logic rdy, input logic rsp, input logic [DW-1:0] dat);
    chk({tag, ".hready"}, {31'd0, hready}, {31'd0, rdy});
    chk({tag, ".hresp"},  {31'd0, hresp},  {31'd0, rsp});
    chk({tag, ".hrdata"}, hrdata, dat);
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge hclk);
    #1;
  endtask

  initial begin
    hresetn = 1'b0; hsel = 4'b0000; htrans = 2'b00;
    hreadyout_s0 = 1'b1; hreadyout_s1 = 1'b1; hreadyout_s2 = 1'b1;
    hresp_s0 = 1'b0; hresp_s1 = 1'b0; hresp_s2 = 1'b0;
    hrdata_s0 = 32'h0000_5A50; hrdata_s1 = 32'h1111_0001; hrdata_s2 = 32'h2222_0002;
    #1 chk_bus("reset", 1'b1, 1'b0, 32'h0);
    #2 hresetn = 1'b1;

    // Unmapped IDLE/BUSY: never an error.
    cyc(); hsel = 4'b0000; htrans = 2'b00; #1 chk_bus("uidle0", 1'b1, 1'b0, 32'h0);
    cyc(); htrans = 2'b01;                  #1 chk_bus("uidle1", 1'b1, 1'b0, 32'h0);
    cyc(); htrans = 2'b00;                  #1 chk_bus("ubusy",  1'b1, 1'b0, 32'h0);
    cyc();                                  #1 chk_bus("uidle2", 1'b1, 1'b0, 32'h0);

    // Read S1 with two wait states; hsel changes during the stall are ignored.
    hsel = 4'b0010; htrans = 2'b10; hreadyout_s1 = 1'b0; hrdata_s1 = 32'h0;
    cyc(); hsel = 4'b0001;                  #1 chk_bus("s1_w1", 1'b0, 1'b0, 32'h0);
    cyc(); hsel = 4'b0100;                  #1 chk_bus("s1_w2", 1'b0, 1'b0, 32'h0);
    cyc(); hreadyout_s1 = 1'b1; hrdata_s1 = 32'hDEAD_BEEF; hsel = 4'b0000; htrans = 2'b00;
    #1 chk_bus("s1_done", 1'b1, 1'b0, 32'hDEAD_BEEF);
    cyc();                                  #1 chk_bus("s1_after", 1'b1, 1'b0, 32'h0);

    // Unmapped NONSEQ: ERR1, ERR2, then OKAY when followed by IDLE.
    hsel = 4'b0000; htrans = 2'b10;
    cyc(); htrans = 2'b00;                  #1 chk_bus("un_err1", 1'b0, 1'b1, 32'h0);
    cyc();                                  #1 chk_bus("un_err2", 1'b1, 1'b1, 32'h0);
    cyc();                                  #1 chk_bus("un_okay", 1'b1, 1'b0, 32'h0);

    // Reserved bit3 and multi-hot selects are unmapped.
    hsel = 4'b1000; htrans = 2'b11;
    cyc(); hsel = 4'b0000; htrans = 2'b00;  #1 chk_bus("b3_err1", 1'b0, 1'b1, 32'h0);
    cyc(); hsel = 4'b0011; htrans = 2'b10;  #1 chk_bus("b3_err2", 1'b1, 1'b1, 32'h0);
    cyc(); hsel = 4'b0000; htrans = 2'b00;  #1 chk_bus("mh_err1", 1'b0, 1'b1, 32'h0);
    cyc();                                  #1 chk_bus("mh_err2", 1'b1, 1'b1, 32'h0);
    cyc();                                  #1 chk_bus("mh_okay", 1'b1, 1'b0, 32'h0);

    // Pipelined S0 -> S2 with a one-cycle stall from slave0.
    hsel = 4'b0001; htrans = 2'b10; hreadyout_s0 = 1'b0; hrdata_s0 = 32'h0;
    hrdata_s2 = 32'hCAFE_0002;
    cyc(); hsel = 4'b0100;                  #1 chk_bus("p_s0_wait", 1'b0, 1'b0, 32'h0);
    cyc(); hreadyout_s0 = 1'b1; hrdata_s0 = 32'hA5A5_0000;
    #1 chk_bus("p_s0_data", 1'b1, 1'b0, 32'hA5A5_0000);
    cyc(); hsel = 4'b0000; htrans = 2'b00;  #1 chk_bus("p_s2_data", 1'b1, 1'b0, 32'hCAFE_0002);

    // Slave ERROR is passed through untouched, no wait states added.
    hsel = 4'b0100; htrans = 2'b10; hreadyout_s2 = 1'b0; hresp_s2 = 1'b1;
    cyc(); hsel = 4'b0000; htrans = 2'b00;  #1 chk_bus("s2_err1", 1'b0, 1'b1, 32'hCAFE_0002);
    cyc(); hreadyout_s2 = 1'b1;             #1 chk_bus("s2_err2", 1'b1, 1'b1, 32'hCAFE_0002);
    cyc(); hresp_s2 = 1'b0;                 #1 chk_bus("s2_back", 1'b1, 1'b0, 32'h0);

    // Back-to-back unmapped NONSEQ: ERR1, ERR2, ERR1, ERR2.
    hsel = 4'b0000; htrans = 2'b10;
    cyc();                                  #1 chk_bus("bb_e1a", 1'b0, 1'b1, 32'h0);
    cyc();                                  #1 chk_bus("bb_e2a", 1'b1, 1'b1, 32'h0);
    cyc(); htrans = 2'b00;                  #1 chk_bus("bb_e1b", 1'b0, 1'b1, 32'h0);
    cyc();                                  #1 chk_bus("bb_e2b", 1'b1, 1'b1, 32'h0);
    cyc();                                  #1 chk_bus("bb_okay", 1'b1, 1'b0, 32'h0);

    // Reset during the second ERR1 of a back-to-back pair.
    htrans = 2'b10;
    cyc();                                  #1 chk_bus("rr_e1a", 1'b0, 1'b1, 32'h0);
    cyc();                                  #1 chk_bus("rr_e2a", 1'b1, 1'b1, 32'h0);
    cyc(); htrans = 2'b00;                  #1 chk_bus("rr_e1b", 1'b0, 1'b1, 32'h0);
    hresetn = 1'b0;                         #1 chk_bus("rr_rst", 1'b1, 1'b0, 32'h0);
    #2 hresetn = 1'b1;
    cyc();                                  #1 chk_bus("rr_idle", 1'b1, 1'b0, 32'h0);
    htrans = 2'b10;
    cyc(); htrans = 2'b00;                  #1 chk_bus("rr_new_e1", 1'b0, 1'b1, 32'h0);
    cyc();                                  #1 chk_bus("rr_new_e2", 1'b1, 1'b1, 32'h0);

    // Async reset with S1 selected and driving non-reset values.
    hsel = 4'b0010; htrans = 2'b10; hreadyout_s1 = 1'b0; hresp_s1 = 1'b1; hrdata_s1 = 32'h1234_5678;
    cyc(); hsel = 4'b0000; htrans = 2'b00;  #1 chk_bus("s1_sel", 1'b0, 1'b1, 32'h1234_5678);
    #2 hresetn = 1'b0;                      #1 chk_bus("s1_rst", 1'b1, 1'b0, 32'h0);
    #1 hresetn = 1'b1;
    cyc();                                  #1 chk_bus("s1_post", 1'b1, 1'b0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: bench did not complete, expected finish before 20000");
    $fatal(1, "timeout");
  end
endmodule
